ttl_reg_bank: RTL and testbench
===============================

Name: ttl_reg_bank

Overview:
- Parametrised successor to the single octal D-register model in sim_ttl.
- Holds DEPTH registers of WIDTH bits with one write port and one read port.
- Write port supports per-cycle load / increment / decrement / clear operations; read port has an active-low output enable.
- Used as a behavioural stand-in for register-file and counter-register groups on the EDiC data bus: general registers, stack pointer, and similar.

Parameters:
- WIDTH, 8, bits per register (1..32).
- DEPTH, 4, number of registers (2..16, power of two).
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- we  input  1  write-port enable; no state change when 0.
- op  input  2  write operation: 00 load, 01 increment, 10 decrement, 11 clear.
- waddr  input  ADDR_W  write/modify target register.
- wdata  input  WIDTH  load data; used only for op=00.
- raddr  input  ADDR_W  read register select.
- oe_n  input  1  active-low read output enable.
- rdata  output  WIDTH  read data.
- cy  output  1  registered carry/borrow flag of the last write-port operation.
- zero  output  1  combinational; 1 when register[raddr] == 0, independent of oe_n.

Behaviour:
- Reset: rst=1 at a rising edge sets all registers to 0 and cy to 0. Reset overrides we for that edge.
  - A modify operation in the same cycle as reset is discarded.
  - rdata then reflects 0 for the selected register.
- Write, with we=1 at a rising edge, operating on reg[waddr]:
  - op=00 (load): reg <= wdata; cy <= 0.
  - op=01 (increment): reg <= reg+1, modulo 2^WIDTH. cy <= 1 iff the old value was all ones (wrap to 0), else 0.
  - op=10 (decrement): reg <= reg-1, modulo 2^WIDTH. cy <= 1 iff the old value was 0 (wrap to all ones), else 0.
  - op=11 (clear): reg <= 0; cy <= 0.
- When we=0: registers and cy hold.
- Latency: a write is visible on rdata combinationally right after the clock edge that performs it. There is no further pipelining.
- Read: rdata = reg[raddr] combinationally, with no clock involved, as on a 74x670-style file.
- Read-during-write with raddr == waddr: before the edge rdata shows the old value; after the edge it shows the new value. No bypass of wdata.
- Only one register is modified per edge. All other registers are untouched.
- X/Z on we, op or waddr at a rising edge while rst=0 is a model error: $fatal with a message naming the port.
- Arithmetic is unsigned; all carries beyond WIDTH are dropped except as reported on cy.
- No state machine beyond the register array and cy.

Optional Feature:
- Macro: TTL_REG_BANK_TRISTATE_EN.
- Defined:
  - rdata is driven to all-Z whenever oe_n=1 and to reg[raddr] when oe_n=0.
  - The model may then share a bus with other drivers.
- Undefined:
  - rdata always drives reg[raddr].
  - oe_n=1 sampled at any rising clock edge triggers $fatal("ttl_reg_bank tri state cannot be used (oe_n high).").
  - This matches the existing no-tristate policy of the sim_ttl models.
- zero and cy are unaffected by the macro.

Test Plan:
- Reset and clear:
  - Write 0xA5 to reg2, then assert rst for one edge → every register reads 0x00, cy=0, zero=1 for all raddr.
  - Same but with we=1, op=01 during the reset edge → reg stays 0.
- Load and isolation: load 0x3C to reg1 and 0xFF to reg3 on consecutive edges → raddr=1 gives 0x3C, raddr=3 gives 0xFF, reg0 and reg2 remain 0x00, cy=0.
- Increment wrap:
  - reg3=0xFF, op=01 → reg3=0x00, cy=1, zero=1.
  - Next op=01 → reg3=0x01, cy=0.
- Decrement borrow:
  - reg0=0x00, op=10 → reg0=0xFF, cy=1.
  - Next op=10 → 0xFE, cy=0.
  - we=0 for 3 edges → value and cy unchanged.
- Read-during-write: raddr=waddr=2, reg2=0x10, load 0x20 → rdata 0x10 sampled just before the edge, 0x20 just after.
- Output enable:
  - With TTL_REG_BANK_TRISTATE_EN: oe_n=1 → rdata all Z; oe_n=0 → value returns without a clock.
  - Without the macro: oe_n=1 at an edge → simulation terminates via $fatal.

Source files
------------

// File: rtl/ttl_reg_bank.sv
// Register bank: DEPTH x WIDTH registers with one write port (load, increment, decrement, clear)
// and one combinational read port. Define TTL_REG_BANK_TRISTATE_EN to let oe_n tri-state rdata.
module ttl_reg_bank #(
   parameter  int WIDTH  = 8,
   parameter  int DEPTH  = 4,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              oe_n,
   output logic [WIDTH-1:0]  rdata,
   output logic              cy,
   output logic              zero
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_INC  = 2'b01;
   localparam logic [1:0] OP_DEC  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("ttl_reg_bank: WIDTH must be 1..32");
   end
   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ttl_reg_bank: DEPTH must be a power of two in 2..16");
   end

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic             cy_q;
   logic             cy_d;
   logic [WIDTH-1:0] wr_old;
   logic [WIDTH-1:0] rd_val;

   assign wr_old = regs_q[waddr];

   // Only reg[waddr] can change; everything else is copied through.
   always_comb begin
      regs_d = regs_q;
      cy_d   = cy_q;
      if (we) begin
         unique case (op)
            OP_LOAD: begin
               regs_d[waddr] = wdata;
               cy_d          = 1'b0;
            end
            OP_INC: begin
               regs_d[waddr] = wr_old + 1'b1;
               cy_d          = &wr_old;
            end
            OP_DEC: begin
               regs_d[waddr] = wr_old - 1'b1;
               cy_d          = ~|wr_old;
            end
            OP_CLR: begin
               regs_d[waddr] = '0;
               cy_d          = 1'b0;
            end
            default: begin
               regs_d[waddr] = wr_old;
               cy_d          = cy_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         cy_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
         cy_q <= cy_d;
      end
   end

   assign rd_val = regs_q[raddr];
   assign zero   = (rd_val == '0);
   assign cy     = cy_q;

`ifdef TTL_REG_BANK_TRISTATE_EN
   assign rdata = oe_n ? {WIDTH{1'bz}} : rd_val;
`else
   assign rdata = rd_val;
`endif

`ifndef SYNTHESIS
   // Unknown write controls would silently corrupt the model, so stop the run instead.
   always @(posedge clk) begin
      if (rst !== 1'b1) begin
         if ($isunknown(we))    $fatal(1, "ttl_reg_bank: X/Z on we at clock edge");
         if ($isunknown(op))    $fatal(1, "ttl_reg_bank: X/Z on op at clock edge");
         if ($isunknown(waddr)) $fatal(1, "ttl_reg_bank: X/Z on waddr at clock edge");
      end
`ifndef TTL_REG_BANK_TRISTATE_EN
      if (oe_n === 1'b1) $fatal(1, "ttl_reg_bank tri state cannot be used (oe_n high).");
`endif
   end
`endif

endmodule

// File: tb/tb_ttl_reg_bank.sv
// Directed bench for ttl_reg_bank (WIDTH=8, DEPTH=4): vector table plus read-during-write,
// isolation and (when TTL_REG_BANK_TRISTATE_EN is defined) output-enable sequences.
module tb_ttl_reg_bank;

   localparam logic [1:0] LD  = 2'b00;
   localparam logic [1:0] INC = 2'b01;
   localparam logic [1:0] DEC = 2'b10;
   localparam logic [1:0] CLR = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       we = 1'b0;
   logic [1:0] op = 2'b00;
   logic [1:0] waddr = 2'd0;
   logic [7:0] wdata = 8'h00;
   logic [1:0] raddr = 2'd0;
   logic       oe_n = 1'b0;
   logic [7:0] rdata;
   logic       cy;
   logic       zero;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       rst;
      logic       we;
      logic [1:0] op;
      logic [1:0] waddr;
      logic [7:0] wdata;
      logic [1:0] raddr;
      logic [7:0] e_rd;
      logic       e_cy;
      logic       e_z;
   } vec_t;

   vec_t vecs[$];

   ttl_reg_bank #(.WIDTH(8), .DEPTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .op    (op),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .oe_n  (oe_n),
      .rdata (rdata),
      .cy    (cy),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic w, logic [1:0] o, logic [1:0] wa, logic [7:0] wd,
                               logic [1:0] ra, logic [7:0] erd, logic ecy, logic ez);
      vec_t v;
      v.rst = r; v.we = w; v.op = o; v.waddr = wa; v.wdata = wd;
      v.raddr = ra; v.e_rd = erd; v.e_cy = ecy; v.e_z = ez;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      vecs.push_back(mk(1, 0, LD,  0, 8'h00, 0, 8'h00, 0, 1));
      vecs.push_back(mk(0, 1, LD,  2, 8'hA5, 2, 8'hA5, 0, 0));
      vecs.push_back(mk(1, 0, LD,  0, 8'h00, 2, 8'h00, 0, 1));
      vecs.push_back(mk(0, 0, LD,  0, 8'h00, 0, 8'h00, 0, 1));
      vecs.push_back(mk(0, 0, LD,  0, 8'h00, 1, 8'h00, 0, 1));
      vecs.push_back(mk(0, 0, LD,  0, 8'h00, 3, 8'h00, 0, 1));
      vecs.push_back(mk(0, 1, LD,  2, 8'hA5, 2, 8'hA5, 0, 0));
      vecs.push_back(mk(0, 1, DEC, 0, 8'h00, 0, 8'hFF, 1, 0));
      // reset with a pending increment: increment discarded, cy cleared
      vecs.push_back(mk(1, 1, INC, 2, 8'h00, 2, 8'h00, 0, 1));
      vecs.push_back(mk(0, 0, LD,  0, 8'h00, 0, 8'h00, 0, 1));
      vecs.push_back(mk(0, 1, LD,  1, 8'h3C, 1, 8'h3C, 0, 0));
      vecs.push_back(mk(0, 1, LD,  3, 8'hFF, 3, 8'hFF, 0, 0));
      vecs.push_back(mk(0, 0, LD,  0, 8'h00, 1, 8'h3C, 0, 0));
      vecs.push_back(mk(0, 0, LD,  0, 8'h00, 0, 8'h00, 0, 1));
      vecs.push_back(mk(0, 0, LD,  0, 8'h00, 2, 8'h00, 0, 1));
      vecs.push_back(mk(0, 1, INC, 3, 8'h00, 3, 8'h00, 1, 1));
      vecs.push_back(mk(0, 1, INC, 3, 8'h00, 3, 8'h01, 0, 0));
      vecs.push_back(mk(0, 1, DEC, 0, 8'h00, 0, 8'hFF, 1, 0));
      vecs.push_back(mk(0, 1, DEC, 0, 8'h00, 0, 8'hFE, 0, 0));
      vecs.push_back(mk(0, 0, CLR, 0, 8'h00, 0, 8'hFE, 0, 0));
      vecs.push_back(mk(0, 0, CLR, 0, 8'h00, 0, 8'hFE, 0, 0));
      vecs.push_back(mk(0, 0, CLR, 0, 8'h00, 0, 8'hFE, 0, 0));
      vecs.push_back(mk(0, 1, DEC, 2, 8'h00, 2, 8'hFF, 1, 0));
      // we=0 with live op/wdata: value and cy=1 must hold
      vecs.push_back(mk(0, 0, CLR, 2, 8'h00, 2, 8'hFF, 1, 0));
      vecs.push_back(mk(0, 0, LD,  2, 8'h55, 2, 8'hFF, 1, 0));
      vecs.push_back(mk(0, 0, INC, 2, 8'h00, 2, 8'hFF, 1, 0));
      vecs.push_back(mk(0, 1, CLR, 2, 8'h00, 2, 8'h00, 0, 1));
      vecs.push_back(mk(0, 1, INC, 1, 8'h00, 1, 8'h3D, 0, 0));
      vecs.push_back(mk(0, 1, LD,  2, 8'h10, 2, 8'h10, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst   = vecs[i].rst;
         we    = vecs[i].we;
         op    = vecs[i].op;
         waddr = vecs[i].waddr;
         wdata = vecs[i].wdata;
         raddr = vecs[i].raddr;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vecs[i].e_rd));
         chk($sformatf("vec%0d cy", i),    32'(cy),    32'(vecs[i].e_cy));
         chk($sformatf("vec%0d zero", i),  32'(zero),  32'(vecs[i].e_z));
      end

      // read-during-write on reg2 (holds 0x10): old value before the edge, new after
      @(negedge clk);
      rst = 1'b0; we = 1'b1; op = LD; waddr = 2'd2; wdata = 8'h20; raddr = 2'd2;
      #3;
      chk("rdw before edge", 32'(rdata), 32'h10);
      @(posedge clk);
      #1;
      chk("rdw after edge", 32'(rdata), 32'h20);
      chk("rdw cy", 32'(cy), 32'h0);

      // isolation: other registers unchanged, read is purely combinational
      @(negedge clk);
      we = 1'b0;
      raddr = 2'd0; #1; chk("iso reg0", 32'(rdata), 32'hFE);
      raddr = 2'd1; #1; chk("iso reg1", 32'(rdata), 32'h3D);
      raddr = 2'd3; #1; chk("iso reg3", 32'(rdata), 32'h01);
      chk("iso reg3 zero", 32'(zero), 32'h0);
      raddr = 2'd2; #1; chk("iso reg2", 32'(rdata), 32'h20);

`ifdef TTL_REG_BANK_TRISTATE_EN
      @(negedge clk);
      raddr = 2'd1;
      oe_n = 1'b1;
      #1;
      chk("oe_n high rdata z", 32'(rdata === 8'hzz), 32'h1);
      chk("oe_n high zero", 32'(zero), 32'h0);
      oe_n = 1'b0;
      #1;
      chk("oe_n low rdata", 32'(rdata), 32'h3D);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
